tree_ensemble: RTL and testbench

TREE_ENSEMBLE -- requirements
Module: tree_ensemble

---
 rtl/tree_ensemble.sv | 181 ++++++++++++++++++
 tb/tb_tree_ensemble.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tree_ensemble.sv
// tree_ensemble: walks N_TREES decision trees one node per fetch and sums the reached leaf values.
// Optional feature: define TREE_DEPTH_GUARD_EN to abort a tree after N_NODE_AND_LEAFS compares.
module tree_ensemble #(
    parameter int N_TREES          = 4,
    parameter int N_NODE_AND_LEAFS = 256,
    parameter int N_FEATURE        = 32
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          start,
    output logic                                          busy,
    output logic                                          done,
    output logic [$clog2(N_TREES*N_NODE_AND_LEAFS)-1:0]   node_addr,
    input  logic [63:0]                                   node_data,
    output logic [$clog2(N_FEATURE)-1:0]                  feature_index,
    input  logic signed [31:0]                            feature,
    output logic signed [32+$clog2(N_TREES)-1:0]          result,
    output logic                                          error
);
    localparam int SUM_W  = 32 + $clog2(N_TREES);
    localparam int ADDR_W = $clog2(N_TREES * N_NODE_AND_LEAFS);
    localparam int TREE_W = (N_TREES > 1) ? $clog2(N_TREES) : 1;
    localparam int NODE_W = $clog2(N_NODE_AND_LEAFS);
    localparam int FEAT_W = $clog2(N_FEATURE);

    typedef enum logic [2:0] {
        IDLE,
        FETCH_NODE,
        LATCH_NODE,
        FETCH_FEAT,
        COMPARE,
        ACCUM,
        DONE
    } state_e;

    state_e                    state_q, state_d;
    logic [TREE_W-1:0]         tree_idx_q, tree_idx_d;
    logic [NODE_W-1:0]         node_idx_q, node_idx_d;
    logic signed [31:0]        value_q, value_d;
    logic [NODE_W-1:0]         right_q, right_d;
    logic [FEAT_W-1:0]         feat_idx_q, feat_idx_d;
    logic signed [SUM_W-1:0]   result_q, result_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      advance;
    logic                      last_tree;
    logic                      unused_pad;

`ifdef TREE_DEPTH_GUARD_EN
    localparam logic [NODE_W:0] DEPTH_LIMIT = (NODE_W+1)'(N_NODE_AND_LEAFS);
    logic [NODE_W:0]           depth_q, depth_d;
    logic                      error_q, error_d;
`endif

    assign last_tree  = (int'(tree_idx_q) == N_TREES - 1);
    assign unused_pad = ^{node_data[31:24], node_data[23:16], node_data[15:8], node_data[7:1]};

    always_comb begin
        state_d    = state_q;
        tree_idx_d = tree_idx_q;
        node_idx_d = node_idx_q;
        value_d    = value_q;
        right_d    = right_q;
        feat_idx_d = feat_idx_q;
        result_d   = result_q;
        advance    = 1'b0;
`ifdef TREE_DEPTH_GUARD_EN
        depth_d    = depth_q;
        error_d    = error_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = FETCH_NODE;
                    tree_idx_d = '0;
                    node_idx_d = '0;
                    result_d   = '0;
`ifdef TREE_DEPTH_GUARD_EN
                    depth_d    = '0;
                    error_d    = 1'b0;
`endif
                end
            end
            FETCH_NODE: state_d = LATCH_NODE;
            LATCH_NODE: begin
                value_d = node_data[63:32];
                if (node_data[0]) begin
                    feat_idx_d = node_data[8 +: FEAT_W];
                    right_d    = node_data[16 +: NODE_W];
                    state_d    = FETCH_FEAT;
                end else begin
                    state_d = ACCUM;
                end
            end
            FETCH_FEAT: state_d = COMPARE;
            COMPARE: begin
                state_d = FETCH_NODE;
                if (feature < value_q) begin
                    node_idx_d = node_idx_q + 1'b1;
                end else begin
                    node_idx_d = right_q;
                end
`ifdef TREE_DEPTH_GUARD_EN
                // A runaway tree is dropped: skip straight to the next tree without adding.
                depth_d = depth_q + 1'b1;
                if (depth_d == DEPTH_LIMIT) begin
                    error_d = 1'b1;
                    advance = 1'b1;
                end
`endif
            end
            ACCUM: begin
                result_d = result_q + SUM_W'(value_q);
                advance  = 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (advance) begin
            if (last_tree) begin
                state_d = DONE;
            end else begin
                tree_idx_d = tree_idx_q + 1'b1;
                node_idx_d = '0;
                state_d    = FETCH_NODE;
`ifdef TREE_DEPTH_GUARD_EN
                depth_d    = '0;
`endif
            end
        end

        busy_d = (state_d == FETCH_NODE) || (state_d == LATCH_NODE) || (state_d == FETCH_FEAT) ||
                 (state_d == COMPARE) || (state_d == ACCUM);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            tree_idx_q <= '0;
            node_idx_q <= '0;
            value_q    <= '0;
            right_q    <= '0;
            feat_idx_q <= '0;
            result_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef TREE_DEPTH_GUARD_EN
            depth_q    <= '0;
            error_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tree_idx_q <= tree_idx_d;
            node_idx_q <= node_idx_d;
            value_q    <= value_d;
            right_q    <= right_d;
            feat_idx_q <= feat_idx_d;
            result_q   <= result_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef TREE_DEPTH_GUARD_EN
            depth_q    <= depth_d;
            error_q    <= error_d;
`endif
        end
    end

    assign node_addr     = ADDR_W'({tree_idx_q, node_idx_q});
    assign feature_index = feat_idx_q;
    assign result        = result_q;
    assign busy          = busy_q;
    assign done          = done_q;
`ifdef TREE_DEPTH_GUARD_EN
    assign error         = error_q;
`else
    assign error         = 1'b0;
`endif

endmodule

// File: tb/tb_tree_ensemble.sv
// Directed bench for tree_ensemble: a single-tree instance and a four-tree instance with small memories.
module tb_tree_ensemble;
    logic clk;
    logic rst;

    logic               start1, busy1, done1, error1;
    logic [2:0]         node_addr1, feature_index1;
    logic [63:0]        node_data1;
    logic signed [31:0] feature1;
    logic signed [31:0] result1;

    logic               start4, busy4, done4, error4;
    logic [3:0]         node_addr4;
    logic [2:0]         feature_index4;
    logic [63:0]        node_data4;
    logic signed [31:0] feature4;
    logic signed [33:0] result4;

    logic [63:0]        mem1 [0:7];
    logic [63:0]        mem4 [0:15];
    logic signed [31:0] feat1 [0:7];
    logic signed [31:0] feat4 [0:7];

    int n_checks;
    int n_errors;
    int cyc;
    int ndone;

    int fv28  [4] = '{99, 100, -200, 101};
    int exp28 [4] = '{11, 22, 11, 22};

    tree_ensemble #(.N_TREES(1), .N_NODE_AND_LEAFS(8), .N_FEATURE(8)) u_one (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
        .node_addr(node_addr1), .node_data(node_data1),
        .feature_index(feature_index1), .feature(feature1),
        .result(result1), .error(error1)
    );

    tree_ensemble #(.N_TREES(4), .N_NODE_AND_LEAFS(4), .N_FEATURE(8)) u_four (
        .clk(clk), .rst(rst), .start(start4), .busy(busy4), .done(done4),
        .node_addr(node_addr4), .node_data(node_data4),
        .feature_index(feature_index4), .feature(feature4),
        .result(result4), .error(error4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memories: data appears the cycle after the address.
    always @(posedge clk) begin
        node_data1 <= mem1[node_addr1];
        feature1   <= feat1[feature_index1];
        node_data4 <= mem4[node_addr4];
        feature4   <= feat4[feature_index4];
    end

    function automatic logic [63:0] leaf(input int v);
        return {v, 32'h0};
    endfunction

    function automatic logic [63:0] dec(input int thr, input int right, input int fidx);
        logic [7:0] r;
        logic [7:0] f;
        r = right[7:0];
        f = fidx[7:0];
        return {thr, 8'h00, r, f, 8'h01};
    endfunction

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns cycles until done is sampled high, or -1 when the budget runs out.
    task automatic wait_done(input bit four, input bit hold, input int budget, output int cycles);
        cycles = 0;
        repeat (budget) begin
            step();
            cycles++;
            if (!hold) begin
                start1 = 1'b0;
                start4 = 1'b0;
            end
            if (four ? done4 : done1) return;
        end
        cycles = -1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        start1   = 1'b0;
        start4   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            mem1[i]  = '0;
            feat1[i] = '0;
            feat4[i] = '0;
        end
        for (int i = 0; i < 16; i++) mem4[i] = '0;
        step();
        step();
        rst = 1'b0;

        check("rst_busy1", busy1, 0);
        check("rst_done1", done1, 0);
        check("rst_result1", result1, 0);
        check("rst_error1", error1, 0);
        check("rst_busy4", busy4, 0);
        check("rst_result4", result4, 0);
        check("rst_addr4", node_addr4, 0);
        check("rst_fidx4", feature_index4, 0);

        // Single tree, leaf root: done exactly four cycles after start.
        mem1[0] = leaf(-7);
        start1  = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            start1 = 1'b0;
            if (k < 4) begin
                check("leaf_busy", busy1, 1);
                check("leaf_early_done", done1, 0);
            end else begin
                check("leaf_done", done1, 1);
                check("leaf_busy_in_done", busy1, 0);
                check("leaf_result", result1, -7);
            end
        end
        step();
        check("leaf_done_pulse", done1, 0);
        check("leaf_result_hold", result1, -7);

        // Single decision node: less-than goes left, equal or greater goes right.
        mem1[0] = dec(100, 5, 3);
        mem1[1] = leaf(11);
        mem1[5] = leaf(22);
        for (int i = 0; i < 4; i++) begin
            step();
            feat1[3] = fv28[i];
            start1   = 1'b1;
            wait_done(1'b0, 1'b0, 20, cyc);
            check("dec_latency", cyc, 8);
            check("dec_result", result1, exp28[i]);
        end

        // Four saturated leaves must not overflow the accumulator.
        for (int t = 0; t < 4; t++) mem4[t*4] = leaf(32'h7FFF_FFFF);
        step();
        start4 = 1'b1;
        wait_done(1'b1, 1'b0, 40, cyc);
        check("sat_latency", cyc, 13);
        check("sat_result", result4, 64'sh1_FFFF_FFFC);
        check("sat_error", error4, 0);

        // Reset mid-walk while tree 2 waits for its feature.
        mem4[0]  = leaf(10);
        mem4[4]  = leaf(-3);
        mem4[8]  = dec(50, 2, 1);
        mem4[9]  = leaf(1000);
        mem4[10] = leaf(-2000);
        mem4[12] = leaf(7);
        feat4[1] = 60;
        step();
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        repeat (8) step();
        check("mid_fidx", feature_index4, 1);
        check("mid_addr", node_addr4, 8);
        check("mid_busy", busy4, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_busy", busy4, 0);
        check("midrst_done", done4, 0);
        check("midrst_result", result4, 0);
        check("midrst_error", error4, 0);
        check("midrst_addr", node_addr4, 0);
        check("midrst_fidx", feature_index4, 0);
        start4 = 1'b1;
        wait_done(1'b1, 1'b0, 40, cyc);
        check("after_rst_latency", cyc, 17);
        check("after_rst_result", result4, -1986);

        // Reset wins over a simultaneous start.
        step();
        rst    = 1'b1;
        start4 = 1'b1;
        step();
        rst    = 1'b0;
        start4 = 1'b0;
        check("rst_vs_start_busy", busy4, 0);
        check("rst_vs_start_result", result4, 0);
        step();
        check("rst_vs_start_idle", busy4, 0);

        // Start held high: back-to-back runs separated by one idle cycle.
        feat4[1] = 49;
        start4   = 1'b1;
        wait_done(1'b1, 1'b1, 40, cyc);
        check("held_first_latency", cyc, 17);
        check("held_first_result", result4, 1014);
        feat4[1] = 60;
        step();
        check("held_gap_done", done4, 0);
        check("held_gap_busy", busy4, 0);
        step();
        check("held_restart_busy", busy4, 1);
        wait_done(1'b1, 1'b1, 40, cyc);
        start4 = 1'b0;
        check("held_second_latency", cyc, 16);
        check("held_second_result", result4, -1986);
        step();
        check("held_done_pulse", done4, 0);
        step();
        check("held_stop_busy", busy4, 0);

        // Tree 1 loops on itself: node 0 always takes right index 0.
        mem4[4]  = dec(0, 0, 0);
        mem4[8]  = leaf(1000);
        feat4[0] = 5;
        step();
        start4 = 1'b1;
`ifdef TREE_DEPTH_GUARD_EN
        wait_done(1'b1, 1'b0, 60, cyc);
        check("guard_latency", cyc, 26);
        check("guard_result", result4, 1017);
        check("guard_error", error4, 1);
        step();
        check("guard_error_sticky", error4, 1);
`else
        ndone = 0;
        for (int k = 0; k < 60; k++) begin
            step();
            start4 = 1'b0;
            if (done4) ndone++;
        end
        check("cyclic_no_done", ndone, 0);
        check("cyclic_busy", busy4, 1);
        check("cyclic_error", error4, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("cyclic_rst_busy", busy4, 0);
`endif

        // A clean run afterwards clears the flag and sums normally.
        mem4[4] = leaf(-3);
        start4  = 1'b1;
        wait_done(1'b1, 1'b0, 40, cyc);
        check("clean_latency", cyc, 13);
        check("clean_result", result4, 1014);
        check("clean_error", error4, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
